ip_proto_dispatch: RTL and testbench
====================================

IP_PROTO_DISPATCH -- requirements
Module: ip_proto_dispatch

Interface
REQ-001 SHALL have parameter DST_ID_W, default 1, the width of the destination ID returned by the protocol CAM.
REQ-002 SHALL have parameter DATA_W, default 256, the payload bus width in bits.
REQ-003 SHALL have parameter META_W, default 64, the width of the opaque header metadata passed through unchanged.
REQ-004 SHALL have parameter PADBYTES_W, default $clog2(DATA_W/8), the width of the padbytes field.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; the ports are:
  clk  in  1  clock
  rst  in  1  async active-high reset
  src_dispatch_hdr_val  in  1  header valid
  src_dispatch_hdr_protocol  in  `PROTOCOL_W  IP protocol field
  src_dispatch_hdr_meta  in  META_W  metadata
  dispatch_src_hdr_rdy  out  1  header ready
  src_dispatch_data_val  in  1  payload beat valid
  src_dispatch_data  in  DATA_W  payload
  src_dispatch_data_last  in  1  final beat
  src_dispatch_data_padbytes  in  PADBYTES_W  invalid bytes in the final beat
  dispatch_src_data_rdy  out  1  payload ready
  rd_cam_val  out  1  CAM lookup strobe
  rd_cam_tag  out  `PROTOCOL_W  lookup key
  rd_cam_data  in  DST_ID_W  matched destination
  rd_cam_hit  in  1  match, valid in the same cycle as the lookup
  dispatch_dst_hdr_val  out  1  header valid to the destination
  dispatch_dst_hdr_meta  out  META_W  metadata
  dispatch_dst_id  out  DST_ID_W  destination ID
  dst_dispatch_hdr_rdy  in  1  destination header ready
  dispatch_dst_data_val, dispatch_dst_data, dispatch_dst_data_last, dispatch_dst_data_padbytes  out  payload to the destination
  dst_dispatch_data_rdy  in  1  destination payload ready

Function
REQ-006 SHALL implement an FSM with states IDLE, LOOKUP, HDR_OUT, DATA_PASS and DATA_DRAIN.
REQ-007 In IDLE, dispatch_src_hdr_rdy SHALL be 1; on a header handshake the block SHALL register the protocol and meta fields and move to LOOKUP.
REQ-008 In LOOKUP, rd_cam_val SHALL be 1 and rd_cam_tag SHALL equal the registered protocol; the block SHALL register rd_cam_hit and rd_cam_data, then go to HDR_OUT on a hit or DATA_DRAIN on a miss; LOOKUP lasts exactly one cycle.
REQ-009 rd_cam_val SHALL be 0 in every state other than LOOKUP.
REQ-010 In HDR_OUT, dispatch_dst_hdr_val SHALL be 1, driven from registers, with the registered meta and ID held stable until the handshake; on the handshake the FSM SHALL go to DATA_PASS.
REQ-011 Header latency SHALL be exactly 2 cycles: header accepted in cycle N, dispatch_dst_hdr_val asserted in cycle N+2.
REQ-012 In DATA_PASS, the payload path SHALL be combinational: dst val = src val, src rdy = dst rdy, and data, last and padbytes passed straight through.
REQ-013 In DATA_PASS, a handshake with last=1 SHALL return the FSM to IDLE.
REQ-014 In DATA_DRAIN, dispatch_src_data_rdy SHALL be 1 and dispatch_dst_data_val SHALL be 0; a beat with last=1 SHALL return the FSM to IDLE.
REQ-015 dispatch_src_data_rdy and dispatch_dst_data_val SHALL be 0 in IDLE, LOOKUP and HDR_OUT; dispatch_src_hdr_rdy SHALL be 0 outside IDLE.
REQ-016 A single-beat packet (last on the first beat) SHALL be handled like any other packet, with no extra cycles.
REQ-017 Header and payload SHALL be processed one packet at a time, with one idle cycle between a last handshake and the next header acceptance.

Reset
REQ-018 Asserting rst SHALL force the FSM to IDLE and clear all registered fields and counters.
REQ-019 While rst is asserted and in the first cycle after release, all val and rdy outputs SHALL be 0, except dispatch_src_hdr_rdy, which SHALL be 1 after release.
REQ-020 If rst is asserted mid-packet, any in-flight beats SHALL be abandoned; upstream SHALL be reset together with this block.

Configuration
REQ-021 When IP_DISPATCH_STATS_EN is defined, the block SHALL expose 32-bit outputs dispatch_pass_cnt and dispatch_drop_cnt.
REQ-022 These counters SHALL increment on LOOKUP exit on a hit or a miss respectively, and SHALL wrap modulo 2^32.
REQ-023 When IP_DISPATCH_STATS_EN is undefined, these ports and counters SHALL be absent.

Structure
REQ-024 The state enum SHALL live in a shared package, ip_proto_dispatch_pkg; `PROTOCOL_W SHALL come from the existing protocol defines.
REQ-025 The counters SHALL be in a sub-module, ip_dispatch_stats, instantiated only under IP_DISPATCH_STATS_EN; the CAM SHALL remain external.

Verification
REQ-026 Protocol 17 with the CAM hitting, ID 0, and a 3-beat packet -> dst header with id=0 in cycle N+2, 3 beats forwarded in order, last with padbytes=5 matching the input.
REQ-027 Protocol 6 with the CAM missing and a 4-beat packet -> no dst header or data valid, all 4 beats accepted, drop_cnt=1.
REQ-028 dst_dispatch_hdr_rdy held at 0 for 3 cycles -> header val, meta and ID held stable, dispatch_src_data_rdy=0 throughout.
REQ-029 Back-to-back single-beat hit packets -> second header accepted one cycle after the first last handshake, pass_cnt=2.
REQ-030 rst asserted during beat 2 of DATA_PASS -> next cycle FSM in IDLE, all dst val outputs 0, counters 0.

Source files
------------

// File: rtl/ip_proto_dispatch_pkg.sv
// Shared types for the IP protocol dispatcher: FSM state encoding and counter width.
// Falls back to an 8-bit protocol field when the protocol defines are not already loaded.
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif

package ip_proto_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_HDR_OUT    = 3'd2,
    ST_DATA_PASS  = 3'd3,
    ST_DATA_DRAIN = 3'd4
  } dispatch_state_e;

  localparam int STATS_CNT_W = 32;

endpackage

// File: rtl/ip_dispatch_stats.sv
// Pass/drop packet counters for the dispatcher, built only when IP_DISPATCH_STATS_EN is defined.
// Counters wrap naturally at 2^32.
`ifdef IP_DISPATCH_STATS_EN
module ip_dispatch_stats
  import ip_proto_dispatch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pass_inc,
  input  logic                   drop_inc,
  output logic [STATS_CNT_W-1:0] pass_cnt,
  output logic [STATS_CNT_W-1:0] drop_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_inc) pass_cnt <= pass_cnt + 1'b1;
      if (drop_inc) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ip_proto_dispatch.sv
// Routes one packet at a time to a destination chosen by an external protocol CAM; misses are drained.
// Optional pass/drop counters are enabled with IP_DISPATCH_STATS_EN.
//
//   state         | meaning
//   --------------+-------------------------------------------------
//   ST_IDLE       | ready for a header, payload blocked
//   ST_LOOKUP     | single-cycle CAM lookup on the registered protocol
//   ST_HDR_OUT    | registered header offered to the destination
//   ST_DATA_PASS  | payload forwarded combinationally to destination
//   ST_DATA_DRAIN | payload accepted and discarded until last beat
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif

module ip_proto_dispatch
  import ip_proto_dispatch_pkg::*;
#(
  parameter int DST_ID_W   = 1,
  parameter int DATA_W     = 256,
  parameter int META_W     = 64,
  parameter int PADBYTES_W = $clog2(DATA_W/8)
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   src_dispatch_hdr_val,
  input  logic [`PROTOCOL_W-1:0] src_dispatch_hdr_protocol,
  input  logic [META_W-1:0]      src_dispatch_hdr_meta,
  output logic                   dispatch_src_hdr_rdy,

  input  logic                   src_dispatch_data_val,
  input  logic [DATA_W-1:0]      src_dispatch_data,
  input  logic                   src_dispatch_data_last,
  input  logic [PADBYTES_W-1:0]  src_dispatch_data_padbytes,
  output logic                   dispatch_src_data_rdy,

  output logic                   rd_cam_val,
  output logic [`PROTOCOL_W-1:0] rd_cam_tag,
  input  logic [DST_ID_W-1:0]    rd_cam_data,
  input  logic                   rd_cam_hit,

  output logic                   dispatch_dst_hdr_val,
  output logic [META_W-1:0]      dispatch_dst_hdr_meta,
  output logic [DST_ID_W-1:0]    dispatch_dst_id,
  input  logic                   dst_dispatch_hdr_rdy,

  output logic                   dispatch_dst_data_val,
  output logic [DATA_W-1:0]      dispatch_dst_data,
  output logic                   dispatch_dst_data_last,
  output logic [PADBYTES_W-1:0]  dispatch_dst_data_padbytes,
`ifdef IP_DISPATCH_STATS_EN
  output logic [STATS_CNT_W-1:0] dispatch_pass_cnt,
  output logic [STATS_CNT_W-1:0] dispatch_drop_cnt,
`endif
  input  logic                   dst_dispatch_data_rdy
);

  dispatch_state_e state, state_nxt;

  logic [`PROTOCOL_W-1:0] proto_q;
  logic [META_W-1:0]      meta_q;
  logic [DST_ID_W-1:0]    id_q;
  logic                   hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Header fields are captured only at their handshake, so they stay stable through ST_HDR_OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_q <= '0;
      meta_q  <= '0;
      id_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && src_dispatch_hdr_val) begin
        proto_q <= src_dispatch_hdr_protocol;
        meta_q  <= src_dispatch_hdr_meta;
      end
      if (state == ST_LOOKUP) begin
        hit_q <= rd_cam_hit;
        id_q  <= rd_cam_data;
      end
    end
  end

  always_comb begin
    state_nxt             = state;
    dispatch_src_hdr_rdy  = 1'b0;
    rd_cam_val            = 1'b0;
    dispatch_dst_hdr_val  = 1'b0;
    dispatch_src_data_rdy = 1'b0;
    dispatch_dst_data_val = 1'b0;
    case (state)
      ST_IDLE: begin
        // Ready is withheld while reset is held so nothing handshakes into a block being cleared.
        dispatch_src_hdr_rdy = !rst;
        if (src_dispatch_hdr_val) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        rd_cam_val = 1'b1;
        state_nxt  = rd_cam_hit ? ST_HDR_OUT : ST_DATA_DRAIN;
      end
      ST_HDR_OUT: begin
        dispatch_dst_hdr_val = hit_q;
        if (hit_q && dst_dispatch_hdr_rdy) state_nxt = ST_DATA_PASS;
      end
      ST_DATA_PASS: begin
        dispatch_dst_data_val = src_dispatch_data_val;
        dispatch_src_data_rdy = dst_dispatch_data_rdy;
        if (src_dispatch_data_val && dst_dispatch_data_rdy && src_dispatch_data_last)
          state_nxt = ST_IDLE;
      end
      ST_DATA_DRAIN: begin
        dispatch_src_data_rdy = 1'b1;
        if (src_dispatch_data_val && src_dispatch_data_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_cam_tag                 = proto_q;
  assign dispatch_dst_hdr_meta      = meta_q;
  assign dispatch_dst_id            = id_q;
  assign dispatch_dst_data          = src_dispatch_data;
  assign dispatch_dst_data_last     = src_dispatch_data_last;
  assign dispatch_dst_data_padbytes = src_dispatch_data_padbytes;

`ifdef IP_DISPATCH_STATS_EN
  logic lookup_pass, lookup_drop;

  assign lookup_pass = (state == ST_LOOKUP) &&  rd_cam_hit;
  assign lookup_drop = (state == ST_LOOKUP) && !rd_cam_hit;

  ip_dispatch_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .pass_inc (lookup_pass),
    .drop_inc (lookup_drop),
    .pass_cnt (dispatch_pass_cnt),
    .drop_cnt (dispatch_drop_cnt)
  );
`endif

endmodule

// File: tb/tb_ip_proto_dispatch.sv
// Directed bench for ip_proto_dispatch: hit/miss dispatch, header backpressure, back-to-back packets, mid-packet reset.
// Counter checks are compiled in when IP_DISPATCH_STATS_EN is defined.
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif

module tb_ip_proto_dispatch;

  localparam int DST_ID_W   = 1;
  localparam int DATA_W     = 256;
  localparam int META_W     = 64;
  localparam int PADBYTES_W = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   src_dispatch_hdr_val;
  logic [`PROTOCOL_W-1:0] src_dispatch_hdr_protocol;
  logic [META_W-1:0]      src_dispatch_hdr_meta;
  logic                   dispatch_src_hdr_rdy;
  logic                   src_dispatch_data_val;
  logic [DATA_W-1:0]      src_dispatch_data;
  logic                   src_dispatch_data_last;
  logic [PADBYTES_W-1:0]  src_dispatch_data_padbytes;
  logic                   dispatch_src_data_rdy;
  logic                   rd_cam_val;
  logic [`PROTOCOL_W-1:0] rd_cam_tag;
  logic [DST_ID_W-1:0]    rd_cam_data;
  logic                   rd_cam_hit;
  logic                   dispatch_dst_hdr_val;
  logic [META_W-1:0]      dispatch_dst_hdr_meta;
  logic [DST_ID_W-1:0]    dispatch_dst_id;
  logic                   dst_dispatch_hdr_rdy;
  logic                   dispatch_dst_data_val;
  logic [DATA_W-1:0]      dispatch_dst_data;
  logic                   dispatch_dst_data_last;
  logic [PADBYTES_W-1:0]  dispatch_dst_data_padbytes;
  logic                   dst_dispatch_data_rdy;
`ifdef IP_DISPATCH_STATS_EN
  logic [31:0]            dispatch_pass_cnt;
  logic [31:0]            dispatch_drop_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ip_proto_dispatch dut (
    .clk                        (clk),
    .rst                        (rst),
    .src_dispatch_hdr_val       (src_dispatch_hdr_val),
    .src_dispatch_hdr_protocol  (src_dispatch_hdr_protocol),
    .src_dispatch_hdr_meta      (src_dispatch_hdr_meta),
    .dispatch_src_hdr_rdy       (dispatch_src_hdr_rdy),
    .src_dispatch_data_val      (src_dispatch_data_val),
    .src_dispatch_data          (src_dispatch_data),
    .src_dispatch_data_last     (src_dispatch_data_last),
    .src_dispatch_data_padbytes (src_dispatch_data_padbytes),
    .dispatch_src_data_rdy      (dispatch_src_data_rdy),
    .rd_cam_val                 (rd_cam_val),
    .rd_cam_tag                 (rd_cam_tag),
    .rd_cam_data                (rd_cam_data),
    .rd_cam_hit                 (rd_cam_hit),
    .dispatch_dst_hdr_val       (dispatch_dst_hdr_val),
    .dispatch_dst_hdr_meta      (dispatch_dst_hdr_meta),
    .dispatch_dst_id            (dispatch_dst_id),
    .dst_dispatch_hdr_rdy       (dst_dispatch_hdr_rdy),
    .dispatch_dst_data_val      (dispatch_dst_data_val),
    .dispatch_dst_data          (dispatch_dst_data),
    .dispatch_dst_data_last     (dispatch_dst_data_last),
    .dispatch_dst_data_padbytes (dispatch_dst_data_padbytes),
`ifdef IP_DISPATCH_STATS_EN
    .dispatch_pass_cnt          (dispatch_pass_cnt),
    .dispatch_drop_cnt          (dispatch_drop_cnt),
`endif
    .dst_dispatch_data_rdy      (dst_dispatch_data_rdy)
  );

  // CAM model: protocol 17 -> id 0, protocol 1 -> id 1, everything else misses.
  always_comb begin
    rd_cam_hit  = 1'b0;
    rd_cam_data = '0;
    if (rd_cam_val) begin
      case (rd_cam_tag)
        8'd17: begin rd_cam_hit = 1'b1; rd_cam_data = 1'b0; end
        8'd1:  begin rd_cam_hit = 1'b1; rd_cam_data = 1'b1; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATA_W-1:0] beat(input int k);
    logic [31:0] w;
    w = 32'hA5C3_0000 + k;
    return {8{w}};
  endfunction

  // Presents a header in an IDLE cycle, confirms ready, and returns in the following (LOOKUP) cycle.
  task automatic send_hdr(input string tag, input logic [7:0] proto, input logic [63:0] meta);
    src_dispatch_hdr_val      = 1'b1;
    src_dispatch_hdr_protocol = proto;
    src_dispatch_hdr_meta     = meta;
    settle();
    chk({tag, "_hdr_rdy"}, dispatch_src_hdr_rdy, 1'b1);
    tick();
    src_dispatch_hdr_val = 1'b0;
  endtask

  initial begin
    rst                        = 1'b1;
    src_dispatch_hdr_val       = 1'b0;
    src_dispatch_hdr_protocol  = '0;
    src_dispatch_hdr_meta      = '0;
    src_dispatch_data_val      = 1'b0;
    src_dispatch_data          = '0;
    src_dispatch_data_last     = 1'b0;
    src_dispatch_data_padbytes = '0;
    dst_dispatch_hdr_rdy       = 1'b0;
    dst_dispatch_data_rdy      = 1'b0;

    // Reset state
    #2;
    chk("rst_hdr_rdy",  dispatch_src_hdr_rdy, 1'b0);
    chk("rst_data_rdy", dispatch_src_data_rdy, 1'b0);
    chk("rst_cam_val",  rd_cam_val, 1'b0);
    chk("rst_dst_hval", dispatch_dst_hdr_val, 1'b0);
    chk("rst_dst_dval", dispatch_dst_data_val, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rel_hdr_rdy",  dispatch_src_hdr_rdy, 1'b1);
    chk("rel_data_rdy", dispatch_src_data_rdy, 1'b0);
    chk("rel_cam_val",  rd_cam_val, 1'b0);
    chk("rel_dst_hval", dispatch_dst_hdr_val, 1'b0);
    chk("rel_dst_dval", dispatch_dst_data_val, 1'b0);

    // Hit on protocol 17, 3-beat packet with padbytes 5 on last, one stalled beat
    send_hdr("t1", 8'd17, 64'h1111_2222_3333_4444);
    settle();
    chk("t1_cam_val",  rd_cam_val, 1'b1);
    chk("t1_cam_tag",  rd_cam_tag, 8'd17);
    chk("t1_hval_n1",  dispatch_dst_hdr_val, 1'b0);
    chk("t1_hrdy_n1",  dispatch_src_hdr_rdy, 1'b0);
    tick();
    settle();
    chk("t1_hval_n2",  dispatch_dst_hdr_val, 1'b1);
    chk("t1_id",       dispatch_dst_id, 1'b0);
    chk("t1_meta",     dispatch_dst_hdr_meta, 64'h1111_2222_3333_4444);
    chk("t1_cam_off",  rd_cam_val, 1'b0);
    dst_dispatch_hdr_rdy = 1'b1;
    tick();
    dst_dispatch_hdr_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src_dispatch_data_val      = 1'b1;
      src_dispatch_data          = beat(k);
      src_dispatch_data_last     = (k == 2);
      src_dispatch_data_padbytes = (k == 2) ? 5'd5 : 5'd0;
      dst_dispatch_data_rdy      = (k != 1);
      settle();
      if (k == 1) begin
        chk("t1_bp_src_rdy", dispatch_src_data_rdy, 1'b0);
        tick();
        dst_dispatch_data_rdy = 1'b1;
        settle();
      end
      chk($sformatf("t1_dval_%0d", k), dispatch_dst_data_val, 1'b1);
      chk($sformatf("t1_data_%0d", k), dispatch_dst_data, beat(k));
      chk($sformatf("t1_last_%0d", k), dispatch_dst_data_last, (k == 2));
      chk($sformatf("t1_srdy_%0d", k), dispatch_src_data_rdy, 1'b1);
      if (k == 2) chk("t1_pad", dispatch_dst_data_padbytes, 5'd5);
      tick();
    end
    src_dispatch_data_val  = 1'b0;
    src_dispatch_data_last = 1'b0;
    settle();
    chk("t1_idle_hrdy", dispatch_src_hdr_rdy, 1'b1);
    chk("t1_idle_dval", dispatch_dst_data_val, 1'b0);

    // Miss on protocol 6, 4-beat packet drained even with destination not ready
    send_hdr("t2", 8'd6, 64'hDEAD_BEEF_0000_0006);
    settle();
    chk("t2_cam_val", rd_cam_val, 1'b1);
    chk("t2_cam_tag", rd_cam_tag, 8'd6);
    tick();
    dst_dispatch_data_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_dispatch_data_val  = 1'b1;
      src_dispatch_data      = beat(10 + k);
      src_dispatch_data_last = (k == 3);
      settle();
      chk($sformatf("t2_srdy_%0d", k), dispatch_src_data_rdy, 1'b1);
      chk($sformatf("t2_dval_%0d", k), dispatch_dst_data_val, 1'b0);
      chk($sformatf("t2_hval_%0d", k), dispatch_dst_hdr_val, 1'b0);
      tick();
    end
    src_dispatch_data_val  = 1'b0;
    src_dispatch_data_last = 1'b0;
    settle();
    chk("t2_idle_hrdy", dispatch_src_hdr_rdy, 1'b1);
`ifdef IP_DISPATCH_STATS_EN
    chk("t2_drop_cnt", dispatch_drop_cnt, 32'd1);
    chk("t2_pass_cnt", dispatch_pass_cnt, 32'd1);
`endif

    // Header backpressure for 3 cycles with a payload beat already waiting
    send_hdr("t3", 8'd17, 64'h0C0C_0C0C_5555_AAAA);
    src_dispatch_data_val      = 1'b1;
    src_dispatch_data          = beat(20);
    src_dispatch_data_last     = 1'b1;
    src_dispatch_data_padbytes = 5'd3;
    dst_dispatch_data_rdy      = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t3_hval_%0d", c), dispatch_dst_hdr_val, 1'b1);
      chk($sformatf("t3_meta_%0d", c), dispatch_dst_hdr_meta, 64'h0C0C_0C0C_5555_AAAA);
      chk($sformatf("t3_id_%0d", c),   dispatch_dst_id, 1'b0);
      chk($sformatf("t3_srdy_%0d", c), dispatch_src_data_rdy, 1'b0);
      chk($sformatf("t3_dval_%0d", c), dispatch_dst_data_val, 1'b0);
      tick();
    end
    dst_dispatch_hdr_rdy = 1'b1;
    tick();
    dst_dispatch_hdr_rdy = 1'b0;
    settle();
    chk("t3_single_dval", dispatch_dst_data_val, 1'b1);
    chk("t3_single_last", dispatch_dst_data_last, 1'b1);
    chk("t3_single_pad",  dispatch_dst_data_padbytes, 5'd3);
    tick();
    src_dispatch_data_val  = 1'b0;
    src_dispatch_data_last = 1'b0;

    // Back-to-back single-beat hits after a fresh reset
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    settle();
    send_hdr("t4a", 8'd1, 64'h0000_0000_0000_00A1);
    tick();
    settle();
    chk("t4a_hval", dispatch_dst_hdr_val, 1'b1);
    chk("t4a_id",   dispatch_dst_id, 1'b1);
    dst_dispatch_hdr_rdy = 1'b1;
    tick();
    dst_dispatch_hdr_rdy       = 1'b0;
    src_dispatch_data_val      = 1'b1;
    src_dispatch_data          = beat(30);
    src_dispatch_data_last     = 1'b1;
    src_dispatch_data_padbytes = 5'd0;
    dst_dispatch_data_rdy      = 1'b1;
    src_dispatch_hdr_val       = 1'b1;
    src_dispatch_hdr_protocol  = 8'd17;
    src_dispatch_hdr_meta      = 64'h0000_0000_0000_00B2;
    settle();
    chk("t4a_srdy",      dispatch_src_data_rdy, 1'b1);
    chk("t4_hrdy_busy",  dispatch_src_hdr_rdy, 1'b0);
    tick();
    src_dispatch_data_val = 1'b0;
    settle();
    chk("t4b_hrdy", dispatch_src_hdr_rdy, 1'b1);
    tick();
    src_dispatch_hdr_val = 1'b0;
    settle();
    chk("t4b_cam_val", rd_cam_val, 1'b1);
    chk("t4b_cam_tag", rd_cam_tag, 8'd17);
    tick();
    settle();
    chk("t4b_hval", dispatch_dst_hdr_val, 1'b1);
    chk("t4b_meta", dispatch_dst_hdr_meta, 64'h0000_0000_0000_00B2);
    chk("t4b_id",   dispatch_dst_id, 1'b0);
    dst_dispatch_hdr_rdy = 1'b1;
    tick();
    dst_dispatch_hdr_rdy  = 1'b0;
    src_dispatch_data_val = 1'b1;
    settle();
    chk("t4b_dval", dispatch_dst_data_val, 1'b1);
    tick();
    src_dispatch_data_val  = 1'b0;
    src_dispatch_data_last = 1'b0;
    settle();
    chk("t4_idle_hrdy", dispatch_src_hdr_rdy, 1'b1);
`ifdef IP_DISPATCH_STATS_EN
    chk("t4_pass_cnt", dispatch_pass_cnt, 32'd2);
    chk("t4_drop_cnt", dispatch_drop_cnt, 32'd0);
`endif

    // Reset during beat 2 of a forwarded packet
    send_hdr("t5", 8'd17, 64'h5555_0000_0000_0005);
    tick();
    dst_dispatch_hdr_rdy = 1'b1;
    tick();
    dst_dispatch_hdr_rdy       = 1'b0;
    src_dispatch_data_val      = 1'b1;
    src_dispatch_data          = beat(40);
    src_dispatch_data_last     = 1'b0;
    dst_dispatch_data_rdy      = 1'b1;
    settle();
    chk("t5_beat1_dval", dispatch_dst_data_val, 1'b1);
    tick();
    src_dispatch_data = beat(41);
    settle();
    chk("t5_beat2_dval", dispatch_dst_data_val, 1'b1);
    rst = 1'b1;
    settle();
    chk("t5_rst_dval", dispatch_dst_data_val, 1'b0);
    chk("t5_rst_srdy", dispatch_src_data_rdy, 1'b0);
    tick();
    settle();
    chk("t5_next_dval", dispatch_dst_data_val, 1'b0);
    chk("t5_next_hval", dispatch_dst_hdr_val, 1'b0);
    chk("t5_next_hrdy", dispatch_src_hdr_rdy, 1'b0);
`ifdef IP_DISPATCH_STATS_EN
    chk("t5_pass_cnt", dispatch_pass_cnt, 32'd0);
    chk("t5_drop_cnt", dispatch_drop_cnt, 32'd0);
`endif
    src_dispatch_data_val = 1'b0;
    rst = 1'b0;
    settle();
    chk("t5_rel_hrdy", dispatch_src_hdr_rdy, 1'b1);
    chk("t5_rel_dval", dispatch_dst_data_val, 1'b0);
    chk("t5_rel_meta", dispatch_dst_hdr_meta, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
